// File: rtl/multicycle_ctrl.sv
// Purpose : Moore main controller for the multicycle RV32I core (FSM that sequences
//           fetch / decode / execute / memory / writeback over the shared datapath).
// Latency : beq 3, R/I/sw/jal 4, lw 5 cycles; +1 cycle per mem_ready=0 in FETCH/MEMREAD/MEMWR.
// Backpr. : mem_ready=0 holds FETCH, MEMREAD and MEMWR; mem_ready is ignored in every other state.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset), returns the FSM to FETCH
//   op         IR opcode field; sampled for sequencing in DECODE and MEMADR only
//   mem_ready  memory accepts the current access
//   AdrSrc     memory address select       (0 = PC, 1 = ALUOut)
//   IRWrite    load IR and OldPC
//   ALUSrcA    ALU A select                (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB    ALU B select                (00 rs2, 01 ImmExt, 10 const 4)
//   ALUOp      to aludec                   (00 add, 01 sub/branch, 10 funct)
//   ResultSrc  result select               (00 ALUOut, 01 Data, 10 ALUResult)
//   ImmSrc     immediate format from op    (00 I, 01 S, 10 B, 11 J)
//   PCUpdate   unconditional PC write
//   Branch     conditional PC write (beq), combined with Zero outside
//   RegWrite   register file write enable
//   MemWrite   memory write enable
//   retire     one-cycle pulse in the last cycle of each instruction
//   illegal    sticky: an unimplemented opcode was decoded (held in TRAP)
//   state_dbg  current state encoding, debug only

module multicycle_ctrl #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      op,
  input  logic            mem_ready,
  output logic            AdrSrc,
  output logic            IRWrite,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ImmSrc,
  output logic            PCUpdate,
  output logic            Branch,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            retire,
  output logic            illegal,
  output logic [ST_W-1:0] state_dbg
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Encoding follows declaration order (FETCH = 0 ... TRAP = 11); state_dbg
  // exposes it directly, so keep the order stable for debug tooling.
  typedef enum logic [ST_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  state_t state;
  state_t nextState;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= nextState;
    end
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = S_FETCH;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ResultSrc = 2'b00;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into PC in the same cycle the
        // instruction is accepted, so both writes follow mem_ready.
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        nextState = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // OldPC + ImmExt: branch/jump target parked in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: nextState = S_MEMADR;
          OP_R:         nextState = S_EXECR;
          OP_I:         nextState = S_EXECI;
          OP_BEQ:       nextState = S_BEQ;
          OP_JAL:       nextState = S_JAL;
          default:      nextState = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nextState = (op == OP_SW) ? S_MEMWR : S_MEMREAD;
      end

      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        nextState = mem_ready ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end

      S_MEMWR: begin
        // Write enable stays up for the whole stall; the store retires on
        // the cycle the memory finally accepts it.
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        retire    = mem_ready;
        nextState = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_EXECR: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b10;
        nextState = S_ALUWB;
      end

      S_EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 2'b10;
        nextState = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end

      S_BEQ: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        Branch    = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end

      S_JAL: begin
        // PC <- target held in ALUOut; ALU computes OldPC+4 into ALUOut
        // for the link write in ALUWB.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        PCUpdate  = 1'b1;
        nextState = S_ALUWB;
      end

      S_TRAP: begin
        illegal   = 1'b1;
        nextState = S_TRAP;
      end

      default: begin
        nextState = S_FETCH;
      end
    endcase

    // The state register already sits in FETCH during reset, but FETCH's
    // enables follow mem_ready; suppress every enable so nothing is written.
    if (!reset) begin
      IRWrite  = 1'b0;
      PCUpdate = 1'b0;
      Branch   = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Immediate format: purely from op, independent of state
  // ---------------------------------------------------------------------------
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       memReady;
  logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, retire, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
  logic [3:0] stateDbg;

  multicycle_ctrl #(.ST_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .mem_ready (memReady),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .ImmSrc    (ImmSrc),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .retire    (retire),
    .illegal   (illegal),
    .state_dbg (stateDbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State encodings (declaration order in the design)
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_BAD = 7'b1110011;

  // Control word: {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
  //                PCUpdate, Branch, RegWrite, MemWrite, retire, illegal}
  logic [15:0] actCtl;
  assign actCtl = {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                   PCUpdate, Branch, RegWrite, MemWrite, retire, illegal};

  function automatic logic [15:0] ctl(input logic adr, input logic irw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] aop, input logic [1:0] res,
                                      input logic pcu, input logic br, input logic rw,
                                      input logic mw, input logic ret, input logic ill);
    return {adr, irw, a, b, aop, res, pcu, br, rw, mw, ret, ill};
  endfunction

  logic [15:0] cFetchRdy, cFetchWait, cDecode, cMemAdr, cMemRead, cMemWb, cMemWrWait,
               cMemWrRdy, cExecR, cExecI, cAluWb, cBeq, cJal, cTrap;

  typedef struct {
    string      name;
    logic       rstN;
    logic [6:0] op;
    logic       memReady;
    logic [3:0] expState;
    logic [15:0] expCtl;
    logic [1:0] expImm;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void add(input string name, input logic rstN, input logic [6:0] o,
                              input logic mr, input logic [3:0] st, input logic [15:0] c,
                              input logic [1:0] imm);
    vec_t v;
    v.name = name; v.rstN = rstN; v.op = o; v.memReady = mr;
    v.expState = st; v.expCtl = c; v.expImm = imm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] st, input logic [15:0] c,
                       input logic [1:0] imm);
    checks++;
    if (stateDbg !== st || actCtl !== c || ImmSrc !== imm) begin
      failures++;
      $display("FAIL %s: got state=%0d ctl=%h imm=%b, expected state=%0d ctl=%h imm=%b",
               name, stateDbg, actCtl, ImmSrc, st, c, imm);
    end
  endtask

  initial begin
    cFetchRdy  = ctl(0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0);
    cFetchWait = ctl(0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
    cDecode    = ctl(0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    cMemAdr    = ctl(0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    cMemRead   = ctl(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    cMemWb     = ctl(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 1, 0);
    cMemWrWait = ctl(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
    cMemWrRdy  = ctl(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0);
    cExecR     = ctl(0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    cExecI     = ctl(0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    cAluWb     = ctl(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0);
    cBeq       = ctl(0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1, 0, 0, 1, 0);
    cJal       = ctl(0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    cTrap      = ctl(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);

    // One record per clock cycle: inputs applied, outputs checked before the edge.
    add("rst_hold",    0, OP_R,   1, FETCH,   cFetchWait, 2'b00);
    add("r_fetch",     1, OP_R,   1, FETCH,   cFetchRdy,  2'b00);
    add("r_decode",    1, OP_R,   1, DECODE,  cDecode,    2'b00);
    add("r_execr",     1, OP_R,   0, EXECR,   cExecR,     2'b00);
    add("r_aluwb",     1, OP_R,   0, ALUWB,   cAluWb,     2'b00);
    add("lw_fwait1",   1, OP_LW,  0, FETCH,   cFetchWait, 2'b00);
    add("lw_fwait2",   1, OP_LW,  0, FETCH,   cFetchWait, 2'b00);
    add("lw_fetch",    1, OP_LW,  1, FETCH,   cFetchRdy,  2'b00);
    add("lw_decode",   1, OP_LW,  1, DECODE,  cDecode,    2'b00);
    add("lw_memadr",   1, OP_LW,  0, MEMADR,  cMemAdr,    2'b00);
    add("lw_rdwait",   1, OP_LW,  0, MEMREAD, cMemRead,   2'b00);
    add("lw_memread",  1, OP_LW,  1, MEMREAD, cMemRead,   2'b00);
    add("lw_memwb",    1, OP_LW,  1, MEMWB,   cMemWb,     2'b00);
    add("sw_fetch",    1, OP_SW,  1, FETCH,   cFetchRdy,  2'b01);
    add("sw_decode",   1, OP_SW,  1, DECODE,  cDecode,    2'b01);
    add("sw_memadr",   1, OP_SW,  1, MEMADR,  cMemAdr,    2'b01);
    add("sw_wait1",    1, OP_SW,  0, MEMWR,   cMemWrWait, 2'b01);
    add("sw_wait2",    1, OP_SW,  0, MEMWR,   cMemWrWait, 2'b01);
    add("sw_wait3",    1, OP_SW,  0, MEMWR,   cMemWrWait, 2'b01);
    add("sw_accept",   1, OP_SW,  1, MEMWR,   cMemWrRdy,  2'b01);
    add("beq_fetch",   1, OP_BEQ, 1, FETCH,   cFetchRdy,  2'b10);
    add("beq_decode",  1, OP_BEQ, 1, DECODE,  cDecode,    2'b10);
    add("beq_exec",    1, OP_BEQ, 1, BEQ,     cBeq,       2'b10);
    add("jal_fetch",   1, OP_JAL, 1, FETCH,   cFetchRdy,  2'b11);
    add("jal_decode",  1, OP_JAL, 1, DECODE,  cDecode,    2'b11);
    add("jal_jal",     1, OP_JAL, 1, JAL,     cJal,       2'b11);
    add("jal_aluwb",   1, OP_JAL, 1, ALUWB,   cAluWb,     2'b11);
    add("i_fetch",     1, OP_I,   1, FETCH,   cFetchRdy,  2'b00);
    add("i_decode",    1, OP_I,   1, DECODE,  cDecode,    2'b00);
    add("i_execi_opchg", 1, OP_SW, 1, EXECI,  cExecI,     2'b01);
    add("i_aluwb_opchg", 1, OP_SW, 1, ALUWB,  cAluWb,     2'b01);
    add("bad_fetch",   1, OP_BAD, 1, FETCH,   cFetchRdy,  2'b00);
    add("bad_decode",  1, OP_BAD, 1, DECODE,  cDecode,    2'b00);
    add("bad_trap",    1, OP_BAD, 1, TRAP,    cTrap,      2'b00);

    foreach (vecs[i]) begin
      reset    = vecs[i].rstN;
      op       = vecs[i].op;
      memReady = vecs[i].memReady;
      #2;
      check(vecs[i].name, vecs[i].expState, vecs[i].expCtl, vecs[i].expImm);
      @(posedge clk);
      #1;
    end

    // TRAP must hold with no enables regardless of mem_ready.
    for (int i = 0; i < 22; i++) begin
      memReady = 1'($urandom_range(0, 1));
      #2;
      check("trap_hold", TRAP, cTrap, 2'b00);
      @(posedge clk);
      #1;
    end

    // Reset clears TRAP/illegal asynchronously; enables stay off even with mem_ready=1.
    memReady = 1'b1;
    reset = 1'b0;
    #1;
    check("trap_reset", FETCH, cFetchWait, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    op = OP_R;
    #1;
    check("post_trap_fetch", FETCH, cFetchRdy, 2'b00);
    @(posedge clk);
    #1;
    check("post_trap_decode", DECODE, cDecode, 2'b00);
    @(posedge clk);
    #1;
    check("mid_execr", EXECR, cExecR, 2'b00);

    // Asynchronous reset in the middle of EXECR, well away from any edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_execr", FETCH, cFetchWait, 2'b00);
    @(posedge clk);
    #1;
    check("reset_held_edge", FETCH, cFetchWait, 2'b00);
    reset = 1'b1;
    #1;
    check("release_fetch", FETCH, cFetchRdy, 2'b00);
    @(posedge clk);
    #1;
    check("release_decode", DECODE, cDecode, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
